mem_access_stage: RTL and testbench

//  MIPS MEM pipeline stage; sits between EX/MEM register and data_memory (word-addressed, async read, sync write, no byte enables).

---
 rtl/mem_stage_pkg.sv | 61 ++++++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings, FSM states and lane helpers for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int NB_WORD = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_e;

    function automatic logic [7:0] get_byte(input logic [NB_WORD-1:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] get_half(input logic [NB_WORD-1:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

    function automatic logic [NB_WORD-1:0] put_byte(input logic [NB_WORD-1:0] word,
                                                     input logic [1:0] lane, input logic [7:0] b);
        logic [NB_WORD-1:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

    function automatic logic [NB_WORD-1:0] put_half(input logic [NB_WORD-1:0] word,
                                                     input logic hi, input logic [15:0] h);
        return hi ? {h, word[15:0]} : {word[31:16], h};
    endfunction

    // Width 2'b10 is an alias of word, so anything not byte/half checks both low bits.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic m;
        case (width)
            WIDTH_BYTE: m = 1'b0;
            WIDTH_HALF: m = addr_lo[0];
            default:    m = |addr_lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational load lane extraction/extension and partial-store lane merge.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]         width,
    input  logic               is_unsigned,
    input  logic [1:0]         lane,
    input  logic [NB_WORD-1:0] read_data,
    input  logic [NB_WORD-1:0] store_data,
    output logic [NB_WORD-1:0] load_data,
    output logic [NB_WORD-1:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = get_byte(read_data, lane);
    assign half_s = get_half(read_data, lane[1]);

    // Select the addressed lane for loads and splice the store lane into the old word.
    always_comb begin
        load_data  = read_data;
        merge_data = store_data;
        case (width)
            WIDTH_BYTE: begin
                load_data  = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
                merge_data = put_byte(read_data, lane, store_data[7:0]);
            end
            WIDTH_HALF: begin
                load_data  = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
                merge_data = put_half(read_data, lane[1], store_data[15:0]);
            end
            default: begin
                load_data  = read_data;
                merge_data = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: address translation, load alignment, SB/SH read-modify-write, MEM/WB registers.
// Optional macro MEM_MISALIGN_TRAP_EN adds misaligned-access trapping and the o_misalign_exc port.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 32,
    parameter int NB_MEM_ADDR = 8,
    parameter int NB_REG      = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [1:0]             i_width,
    input  logic                   i_unsigned,
    input  logic [NB_ADDR-1:0]     i_address,
    input  logic [NB_DATA-1:0]     i_store_data,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic                   i_reg_write,
    input  logic [NB_REG-1:0]      i_rd,
    input  logic [NB_DATA-1:0]     i_mem_read_data,
    output logic [NB_DATA-1:0]     o_mem_address,
    output logic [NB_DATA-1:0]     o_mem_write_data,
    output logic                   o_mem_read_enable,
    output logic                   o_mem_write_enable,
    output logic                   o_mem_valid,
    output logic                   o_stall,
    output logic [NB_DATA-1:0]     o_wb_data,
    output logic [NB_REG-1:0]      o_wb_rd,
    output logic                   o_wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                   o_misalign_exc,
`endif
    output logic                   o_wb_valid
);

    state_e                   state_r;
    logic [NB_MEM_ADDR-1:0]   hold_addr_r;
    logic [NB_DATA-1:0]       hold_data_r;
    logic [NB_DATA-1:0]       hold_alu_r;
    logic [NB_REG-1:0]        hold_rd_r;
    logic                     hold_reg_write_r;
    logic [NB_DATA-1:0]       wb_data_r;
    logic [NB_REG-1:0]        wb_rd_r;
    logic                     wb_reg_write_r;
    logic                     wb_valid_r;

    logic [NB_MEM_ADDR-1:0]   word_addr_s;
    logic [NB_MEM_ADDR-1:0]   addr_s;
    logic [NB_DATA-1:0]       wdata_s;
    logic                     rd_en_s;
    logic                     wr_en_s;
    logic                     stall_s;
    logic                     partial_s;
    logic                     misalign_s;
    logic                     is_load_s;
    logic                     start_rmw_s;
    logic [NB_DATA-1:0]       load_data_s;
    logic [NB_DATA-1:0]       merge_data_s;
    logic                     unused_addr_bits_s;

    // Upper byte-address bits fall outside the RAM and simply wrap.
    assign word_addr_s        = i_address[NB_MEM_ADDR+1:2];
    assign unused_addr_bits_s = ^i_address[NB_ADDR-1:NB_MEM_ADDR+2];
    assign partial_s          = (i_width == WIDTH_BYTE) || (i_width == WIDTH_HALF);
    assign is_load_s          = i_mem_read & ~i_mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = (i_mem_read | i_mem_write) & is_misaligned(i_width, i_address[1:0]);
`else
    assign misalign_s = 1'b0;
`endif
    assign start_rmw_s = i_mem_write & partial_s & ~misalign_s;

    mem_lane_align u_lane_align (
        .width       (i_width),
        .is_unsigned (i_unsigned),
        .lane        (i_address[1:0]),
        .read_data   (i_mem_read_data),
        .store_data  (i_store_data),
        .load_data   (load_data_s),
        .merge_data  (merge_data_s)
    );

    // Memory strobes and stall must act in the same cycle, so they are decoded combinationally.
    always_comb begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
        stall_s = 1'b0;
        addr_s  = word_addr_s;
        wdata_s = i_store_data;
        if (!i_valid) begin
            rd_en_s = 1'b0;
        end else if (state_r == ST_RMW_WRITE) begin
            wr_en_s = 1'b1;
            addr_s  = hold_addr_r;
            wdata_s = hold_data_r;
        end else if (misalign_s) begin
            rd_en_s = 1'b0;
        end else if (start_rmw_s) begin
            rd_en_s = 1'b1;
            stall_s = 1'b1;
        end else if (i_mem_write) begin
            wr_en_s = 1'b1;
        end else if (i_mem_read) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // FSM, RMW hold registers and MEM/WB pipeline register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r          <= ST_IDLE;
            hold_addr_r      <= {NB_MEM_ADDR{1'b0}};
            hold_data_r      <= {NB_DATA{1'b0}};
            hold_alu_r       <= {NB_DATA{1'b0}};
            hold_rd_r        <= {NB_REG{1'b0}};
            hold_reg_write_r <= 1'b0;
            wb_data_r        <= {NB_DATA{1'b0}};
            wb_rd_r          <= {NB_REG{1'b0}};
            wb_reg_write_r   <= 1'b0;
            wb_valid_r       <= 1'b0;
        end else if (!i_valid) begin
            wb_valid_r <= 1'b0;
        end else if (state_r == ST_RMW_WRITE) begin
            state_r        <= ST_IDLE;
            wb_data_r      <= hold_alu_r;
            wb_rd_r        <= hold_rd_r;
            wb_reg_write_r <= hold_reg_write_r;
            wb_valid_r     <= 1'b1;
        end else if (start_rmw_s) begin
            state_r          <= ST_RMW_WRITE;
            hold_addr_r      <= word_addr_s;
            hold_data_r      <= merge_data_s;
            hold_alu_r       <= i_alu_result;
            hold_rd_r        <= i_rd;
            hold_reg_write_r <= i_reg_write;
            wb_valid_r       <= 1'b0;
        end else begin
            wb_data_r      <= (is_load_s && !misalign_s) ? load_data_s : i_alu_result;
            wb_rd_r        <= i_rd;
            wb_reg_write_r <= i_reg_write & ~misalign_s;
            wb_valid_r     <= 1'b1;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_exc_r;

    // Exception flag travels with the MEM/WB entry and lasts one cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            misalign_exc_r <= 1'b0;
        end else if (!i_valid || state_r == ST_RMW_WRITE) begin
            misalign_exc_r <= 1'b0;
        end else begin
            misalign_exc_r <= misalign_s;
        end
    end

    assign o_misalign_exc = misalign_exc_r;
`endif

    assign o_mem_address      = {{(NB_DATA-NB_MEM_ADDR){1'b0}}, addr_s};
    assign o_mem_write_data   = wdata_s;
    assign o_mem_read_enable  = rd_en_s;
    assign o_mem_write_enable = wr_en_s;
    assign o_mem_valid        = rd_en_s | wr_en_s;
    assign o_stall            = stall_s;
    assign o_wb_data          = wb_data_r;
    assign o_wb_rd            = wb_rd_r;
    assign o_wb_reg_write     = wb_reg_write_r;
    assign o_wb_valid         = wb_valid_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed vector bench for mem_access_stage with a word-addressed RAM model.
module tb_mem_access_stage;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [1:0]  i_width = 2'b00;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_address = 32'h0;
    logic [31:0] i_store_data = 32'h0;
    logic [31:0] i_alu_result = 32'h0;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_rd = 5'd0;
    logic [31:0] i_mem_read_data;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_write_data;
    logic        o_mem_read_enable;
    logic        o_mem_write_enable;
    logic        o_mem_valid;
    logic        o_stall;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic        o_wb_valid;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        o_misalign_exc;
`endif

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clock = ~i_clock;

    assign i_mem_read_data = mem[o_mem_address[7:0]];

    always @(posedge i_clock) begin
        if (o_mem_write_enable) mem[o_mem_address[7:0]] <= o_mem_write_data;
    end

    mem_access_stage dut (
        .i_clock            (i_clock),
        .i_reset_n          (i_reset_n),
        .i_valid            (i_valid),
        .i_mem_read         (i_mem_read),
        .i_mem_write        (i_mem_write),
        .i_width            (i_width),
        .i_unsigned         (i_unsigned),
        .i_address          (i_address),
        .i_store_data       (i_store_data),
        .i_alu_result       (i_alu_result),
        .i_reg_write        (i_reg_write),
        .i_rd               (i_rd),
        .i_mem_read_data    (i_mem_read_data),
        .o_mem_address      (o_mem_address),
        .o_mem_write_data   (o_mem_write_data),
        .o_mem_read_enable  (o_mem_read_enable),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_valid        (o_mem_valid),
        .o_stall            (o_stall),
        .o_wb_data          (o_wb_data),
        .o_wb_rd            (o_wb_rd),
        .o_wb_reg_write     (o_wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
        .o_misalign_exc     (o_misalign_exc),
`endif
        .o_wb_valid         (o_wb_valid)
    );

    typedef struct {
        logic        rd_in;
        logic        wr_in;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] alu;
        logic        rw;
        logic [4:0]  rd;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_re;
        logic        exp_we;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rdi, input logic wri, input logic [1:0] w, input logic u,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                                input logic rw, input logic [4:0] rd, input logic cd,
                                input logic [31:0] ed, input logic ere, input logic ewe);
        vec_t v;
        v.rd_in = rdi; v.wr_in = wri; v.width = w; v.uns = u; v.addr = a; v.sdata = sd;
        v.alu = alu; v.rw = rw; v.rd = rd; v.chk_data = cd; v.exp_data = ed;
        v.exp_re = ere; v.exp_we = ewe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rdi, input logic wri, input logic [1:0] w, input logic u,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                          input logic rw, input logic [4:0] rd);
        i_valid = 1'b1; i_mem_read = rdi; i_mem_write = wri; i_width = w; i_unsigned = u;
        i_address = a; i_store_data = sd; i_alu_result = alu; i_reg_write = rw; i_rd = rd;
    endtask

    task automatic do_load(input string name, input logic [31:0] a, input logic [31:0] exp);
        set_in(1'b1, 1'b0, 2'b11, 1'b0, a, 32'h0, 32'h0, 1'b1, 5'd9);
        @(posedge i_clock); #1;
        chk(name, o_wb_data, exp);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h0,   32'h8899AABB, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h4,   32'h11223344, 32'h4, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h1,   32'h0, 32'h1, 1'b1, 5'd3, 1'b1, 32'hFFFFFFAA, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h1,   32'h0, 32'h1, 1'b1, 5'd4, 1'b1, 32'h000000AA, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h2,   32'h0, 32'h2, 1'b1, 5'd5, 1'b1, 32'hFFFF8899, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h2,   32'h0, 32'h2, 1'b1, 5'd6, 1'b1, 32'h00008899, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0, 1'b1, 5'd7, 1'b1, 32'h8899AABB, 1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h3,   32'h0, 32'h3, 1'b1, 5'd8, 1'b1, 32'h00000088, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0,   32'h0, 32'h0, 1'b1, 5'd9, 1'b1, 32'hFFFFAABB, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h6,   32'h0, 32'h6, 1'b1, 5'd10, 1'b1, 32'h00001122, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h77,  32'h0, 32'h12345678, 1'b1, 5'd11, 1'b1, 32'h12345678, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h3FC, 32'hDEADBEEF, 32'h3FC, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h3FC, 32'h0, 32'h3FC, 1'b1, 5'd12, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 2'b11, 1'b0, 32'h8,   32'h0BADF00D, 32'h8, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h8,   32'h0, 32'h8, 1'b1, 5'd13, 1'b1, 32'h0BADF00D, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h400, 32'hCAFEF00D, 32'h400, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[16] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0, 1'b1, 5'd14, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h2,   32'h0, 32'h2, 1'b1, 5'd15, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);

        // Reset state
        #12;
        chk("rst_wb_valid", o_wb_valid, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_wb_rd", o_wb_rd, 32'd0);
        chk("rst_wb_reg_write", o_wb_reg_write, 32'd0);
        chk("rst_strobes", {o_mem_read_enable, o_mem_write_enable, o_mem_valid, o_stall}, 32'd0);
        @(posedge i_clock); #1;
        i_reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].rd_in, vecs[i].wr_in, vecs[i].width, vecs[i].uns, vecs[i].addr,
                   vecs[i].sdata, vecs[i].alu, vecs[i].rw, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_read_en", i), o_mem_read_enable, vecs[i].exp_re);
            chk($sformatf("v%0d_write_en", i), o_mem_write_enable, vecs[i].exp_we);
            chk($sformatf("v%0d_stall", i), o_stall, 32'd0);
            @(posedge i_clock); #1;
            chk($sformatf("v%0d_wb_valid", i), o_wb_valid, 32'd1);
            chk($sformatf("v%0d_wb_rd", i), o_wb_rd, vecs[i].rd);
            chk($sformatf("v%0d_wb_reg_write", i), o_wb_reg_write, vecs[i].rw);
            if (vecs[i].chk_data) chk($sformatf("v%0d_wb_data", i), o_wb_data, vecs[i].exp_data);
        end

        // SB 0x5A to byte 2 of word 1 (0x11223344): stall, then merged write
        set_in(1'b0, 1'b1, 2'b00, 1'b0, 32'h6, 32'h0000005A, 32'h6, 1'b0, 5'd0);
        #1;
        chk("sb_c1_stall", o_stall, 32'd1);
        chk("sb_c1_read_en", o_mem_read_enable, 32'd1);
        chk("sb_c1_write_en", o_mem_write_enable, 32'd0);
        @(posedge i_clock); #1;
        i_address = 32'h0; i_store_data = 32'hFFFFFFFF;
        #1;
        chk("sb_bubble", o_wb_valid, 32'd0);
        chk("sb_c2_stall", o_stall, 32'd0);
        chk("sb_c2_write_en", o_mem_write_enable, 32'd1);
        chk("sb_c2_read_en", o_mem_read_enable, 32'd0);
        chk("sb_c2_addr", o_mem_address, 32'd1);
        chk("sb_c2_wdata", o_mem_write_data, 32'h115A3344);
        @(posedge i_clock); #1;
        chk("sb_exit_valid", o_wb_valid, 32'd1);
        do_load("sb_readback", 32'h4, 32'h115A3344);

        // SH 0xBEEF to upper half of word 2 (0x0BADF00D)
        set_in(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF, 32'hA, 1'b0, 5'd0);
        @(posedge i_clock); #1;
        @(posedge i_clock); #1;
        do_load("sh_readback", 32'h8, 32'hBEEFF00D);

        // i_valid low: no strobes, bubble
        set_in(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1);
        i_valid = 1'b0;
        #1;
        chk("novalid_strobe", o_mem_valid, 32'd0);
        @(posedge i_clock); #1;
        chk("novalid_wb_valid", o_wb_valid, 32'd0);

        // Reset in RMW_WRITE of SH abandons the write
        set_in(1'b0, 1'b1, 2'b01, 1'b0, 32'h8, 32'h00001234, 32'h8, 1'b1, 5'd2);
        @(posedge i_clock); #1;
        chk("rstrmw_pre_write_en", o_mem_write_enable, 32'd1);
        i_valid = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("rstrmw_write_en", o_mem_write_enable, 32'd0);
        chk("rstrmw_wb", {o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data[24:0]}, 32'd0);
        chk("rstrmw_wb_data", o_wb_data, 32'd0);
        @(posedge i_clock); #1;
        i_reset_n = 1'b1;
        set_in(1'b1, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 5'd9);
        #1;
        chk("rstrmw_idle_stall", o_stall, 32'd0);
        chk("rstrmw_idle_read_en", o_mem_read_enable, 32'd1);
        @(posedge i_clock); #1;
        chk("rstrmw_unchanged", o_wb_data, 32'hBEEFF00D);

        i_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
